// File: rtl/pool2x2_stream_ctrl.sv
// pool2x2_stream_ctrl: streaming 2x2 stride-2 signed max-pool scheduler with half-row line buffer
module pool2x2_stream_ctrl #(
    parameter int WIDTH = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);
    localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
    localparam int HD = IMG_W / 2;
    localparam int HW = IMG_W > 2 ? $clog2(HD) : 1;

    if (IMG_W < 2 || IMG_W % 2 != 0 || IMG_H < 2 || IMG_H % 2 != 0) begin : g_bad_dims
        $fatal(1, "pool2x2_stream_ctrl: IMG_W and IMG_H must be even and >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] pair_q, pair_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lb_q [HD];
    logic [HW-1:0]    hidx;
    logic [WIDTH-1:0] pm;
    logic             xfer, col_last, row_last;

    assign hidx       = HW'(col_q >> 1);
    assign col_last   = col_q == CW'(IMG_W - 1);
    assign row_last   = row_q == RW'(IMG_H - 1);
    assign s_ready    = (state_q == RUN) && (!m_valid_q || m_ready);
    assign xfer       = s_valid && s_ready;
    assign pm         = smax(pair_q, s_data);
    assign busy       = state_q != IDLE;
    assign frame_done = done_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;

    // next-state: frame sequencing, raster counters, pair/output registers
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        pair_d    = pair_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        done_d    = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
        end
        if (xfer) begin
            col_d  = col_last ? '0 : col_q + 1'b1;
            row_d  = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
            pair_d = col_q[0] ? pair_q : s_data;
            if (col_q[0] && row_q[0]) begin
                m_data_d  = smax(lb_q[hidx], pm);
                m_valid_d = 1'b1;
            end
            if (col_last && row_last) state_d = DRAIN;
        end
        if (state_q == DRAIN && m_valid_q && m_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pair_q    <= pair_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
        end
    end

    // half-row buffer: horizontal pair maxima of each even row, consumed by the following odd row
    always_ff @(posedge clk) begin
        if (xfer && col_q[0] && !row_q[0]) lb_q[hidx] <= pm;
    end
endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// tb_pool2x2_stream_ctrl: randomized and directed checks of the 2x2 max-pool stream against a frame-level model
module tb_pool2x2_stream_ctrl;
    localparam int WD = 9;

    logic clk = 1'b0;
    logic rst;
    logic st [2], sv [2], sr [2], mv [2], mr [2], bsy [2], fdn [2];
    logic signed [WD-1:0] sd [2], md [2];

    int n_chk = 0, n_fail = 0;
    int img [];
    int exp_q [$];
    int got0 [$], got1 [$];
    int fdc0 = 0, fdc1 = 0;
    int lat_n = 0;
    bit lat_en = 1'b0;
    bit pv0 = 1'b0, pa0 = 1'b0, pa1 = 1'b0, pin_ok = 1'b0;
    int pin = 0;

    always #5 clk = ~clk;

    pool2x2_stream_ctrl #(.WIDTH(WD), .IMG_W(4), .IMG_H(4)) dut_s (
        .clk(clk), .rst(rst), .start(st[0]), .busy(bsy[0]), .frame_done(fdn[0]),
        .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0])
    );

    pool2x2_stream_ctrl #(.WIDTH(WD)) dut_l (
        .clk(clk), .rst(rst), .start(st[1]), .busy(bsy[1]), .frame_done(fdn[1]),
        .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1])
    );

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // output monitors: collect accepted results, check latency and frame_done placement
    always @(negedge clk) begin
        if (lat_en && mv[0] && !pv0) begin
            check("latency", pin_ok ? pin : -9999, md[0]);
            lat_n <= lat_n + 1;
        end
        if (fdn[0]) begin
            fdc0 <= fdc0 + 1;
            check("done_after_last_s", pa0, 1);
            check("busy_at_done_s", bsy[0], 0);
        end
        if (mv[0] && mr[0]) got0.push_back(md[0]);
        pv0    <= mv[0];
        pa0    <= mv[0] && mr[0];
        pin_ok <= sv[0] && sr[0];
        pin    <= sd[0];
    end

    always @(negedge clk) begin
        if (fdn[1]) begin
            fdc1 <= fdc1 + 1;
            check("done_after_last_l", pa1, 1);
            check("busy_at_done_l", bsy[1], 0);
        end
        if (mv[1] && mr[1]) got1.push_back(md[1]);
        pa1 <= mv[1] && mr[1];
    end

    task automatic model(input int w, input int h);
        int m, v;
        exp_q.delete();
        for (int by = 0; by < h / 2; by++)
            for (int bx = 0; bx < w / 2; bx++) begin
                m = img[2 * by * w + 2 * bx];
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        v = img[(2 * by + dy) * w + 2 * bx + dx];
                        if (v > m) m = v;
                    end
                exp_q.push_back(m);
            end
    endtask

    task automatic fill_ramp(input int n);
        img = new[n];
        for (int k = 0; k < n; k++) img[k] = k;
    endtask

    task automatic fill_rand(input int n);
        img = new[n];
        for (int k = 0; k < n; k++) img[k] = int'($urandom_range(511)) - 256;
    endtask

    task automatic drive(input int d, input int n, input int vp, input int rp, input int hold, input bit wait_done);
        int i = 0, cyc = 0;
        bit held = 1'b0;
        @(posedge clk); #1 st[d] = 1'b1;
        @(posedge clk); #1 st[d] = 1'b0;
        while (i < n && cyc < 20000) begin
            if (hold > 0 && !held && mv[d]) begin
                held  = 1'b1;
                mr[d] = 1'b0;
                repeat (hold) begin
                    @(negedge clk);
                    check("hold_data", md[d], exp_q[0]);
                    check("hold_sready", sr[d], 0);
                    @(posedge clk); #1;
                end
            end
            sv[d] = $urandom_range(99) < vp;
            sd[d] = WD'(img[i]);
            mr[d] = $urandom_range(99) < rp;
            @(negedge clk);
            if (sv[d] && sr[d]) i++;
            @(posedge clk); #1;
            cyc++;
        end
        sv[d] = 1'b0;
        check("beats_accepted", i, n);
        while (wait_done && !fdn[d] && cyc < 40000) begin
            mr[d] = $urandom_range(99) < rp;
            @(posedge clk); #1;
            cyc++;
        end
        mr[d] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input int d, input string tag, input int fd_base);
        int got [$];
        if (d == 0) got = got0; else got = got1;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) check({tag, "_data"}, got[k], exp_q[k]);
        check({tag, "_done"}, (d == 0 ? fdc0 : fdc1) - fd_base, 1);
        check({tag, "_busy"}, bsy[d], 0);
    endtask

    initial begin
        int base;
        int neg [16] = '{-256, -1, -3, -200, -5, -7, -100, -2, -10, -10, -10, -10, -10, -10, -10, -10};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0;
            sv[d] = 1'b0;
            mr[d] = 1'b1;
            sd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", bsy[d], 0);
            check("rst_done", fdn[d], 0);
            check("rst_sready", sr[d], 0);
            check("rst_mvalid", mv[d], 0);
            check("rst_mdata", md[d], 0);
        end
        rst = 1'b0;

        fill_ramp(16);
        model(4, 4);
        got0.delete();
        base   = fdc0;
        lat_en = 1'b1;
        drive(0, 16, 100, 100, 0, 1'b1);
        lat_en = 1'b0;
        check("latency_count", lat_n, 4);
        check_frame(0, "ramp", base);

        img = new[16];
        for (int k = 0; k < 16; k++) img[k] = neg[k];
        model(4, 4);
        got0.delete();
        base = fdc0;
        drive(0, 16, 100, 100, 0, 1'b1);
        check_frame(0, "neg", base);

        fill_ramp(16);
        model(4, 4);
        got0.delete();
        base = fdc0;
        drive(0, 16, 100, 100, 5, 1'b1);
        check_frame(0, "backpressure", base);

        for (int r = 0; r < 3; r++) begin
            fill_rand(16);
            model(4, 4);
            got0.delete();
            base = fdc0;
            drive(0, 16, 50, 50, 0, 1'b1);
            check_frame(0, "bubbly", base);
        end

        fill_ramp(16);
        model(4, 4);
        drive(0, 9, 100, 100, 0, 1'b0);
        check("busy_mid_frame", bsy[0], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", bsy[0], 0);
        check("midrst_done", fdn[0], 0);
        check("midrst_sready", sr[0], 0);
        check("midrst_mvalid", mv[0], 0);
        check("midrst_mdata", md[0], 0);
        rst = 1'b0;
        got0.delete();
        base = fdc0;
        drive(0, 16, 100, 100, 0, 1'b1);
        check_frame(0, "after_rst", base);

        for (int f = 0; f < 2; f++) begin
            fill_rand(784);
            model(28, 28);
            got1.delete();
            base = fdc1;
            drive(1, 784, f == 0 ? 100 : 80, f == 0 ? 100 : 70, 0, 1'b1);
            check_frame(1, f == 0 ? "big_f0" : "big_f1", base);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pool2x2_stream_ctrl.md
Name: pool2x2_stream_ctrl

Overview:
- Streaming scheduler for 2x2 max pooling, stride 2.
- Accepts a raster-order (row-major) feature map one pixel per beat and buffers half a row.
- Sequences signed pairwise max comparisons and emits one pooled pixel per 2x2 block over a valid/ready handshake.
- Sits between a convolution/activation output stream and the next layer's input.

Parameters:
- WIDTH, 9, signed pixel width (two's complement).
- IMG_W, 28, input frame width in pixels; must be even, >=2.
- IMG_H, 28, input frame height in pixels; must be even, >=2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; begins a frame when idle.
- busy  output  1  high from accepted start until frame_done.
- frame_done  output  1  one-cycle pulse when the last pooled pixel is accepted downstream.
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block can accept a pixel.
- s_data  input  WIDTH  signed input pixel.
- m_valid  output  1  pooled pixel valid.
- m_ready  input  1  downstream accepts pooled pixel.
- m_data  output  WIDTH  signed pooled pixel.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge), from any state including mid-frame:
  - state=IDLE; busy=0, frame_done=0, s_ready=0, m_valid=0, m_data=0.
  - col/row counters=0, pair register=0.
  - Line buffer contents are don't-care.
- States:
  - IDLE: s_ready=0. start=1 -> RUN, counters cleared, busy=1. start is ignored outside IDLE.
  - RUN: transfers occur when s_valid & s_ready. After the last input beat (row=IMG_H-1, col=IMG_W-1) -> DRAIN.
  - DRAIN: s_ready=0. Wait for the final m_valid&m_ready, then pulse frame_done for exactly 1 cycle, clear busy, return to IDLE.
- Counters:
  - col counts 0..IMG_W-1 and wraps to 0, incrementing row.
  - row counts 0..IMG_H-1.
  - Both advance only on accepted input beats.
- Datapath per accepted beat; all comparisons signed, ties pick either operand (equal value):
  - Even col: pair register <= s_data.
  - Odd col, even row: line buffer[col>>1] <= max(pair, s_data). Line buffer depth IMG_W/2, WIDTH bits.
  - Odd col, odd row: m_data <= max(line buffer[col>>1], max(pair, s_data)); m_valid <= 1.
- Latency: m_valid rises the cycle after the beat that completes the 2x2 block (odd row, odd col).
- Output register:
  - m_data/m_valid hold stable while m_valid=1 and m_ready=0.
  - m_valid clears on m_valid&m_ready unless a new result loads in the same cycle, in which case it stays 1 with new data.
- Backpressure: in RUN, s_ready = ~m_valid | m_ready. Input stalls only while an unaccepted result is pending; there are no dropped or duplicated outputs.
- Throughput: with s_valid=1 and m_ready=1 continuously, 1 pixel/cycle in; (IMG_W/2)*(IMG_H/2) outputs per frame.
- s_valid while in IDLE or DRAIN: ignored, no counter change.
- Simultaneous start and rst: rst wins.
- Parameter check at elaboration: odd IMG_W or IMG_H is a fatal error.

Test Plan:
- IMG_W=4, IMG_H=4; start, then stream 0..15 with m_ready=1 -> outputs 5, 7, 13, 15 in order. Each m_valid is exactly 1 cycle after inputs 5, 7, 13, 15 respectively. frame_done pulses once, 1 cycle after the 15 output is accepted; busy then 0.
- Same frame, values all negative: row0 = -256, -1, -3, -200; row1 = -5, -7, -100, -2; rows 2-3 = -10 -> outputs -1, -2, -10, -10. Confirms signed compare (not unsigned).
- Backpressure: m_ready=0 for 5 cycles while the first result (5) is pending -> m_data holds 5, s_ready=0, no input consumed. After release the output stream is identical to test 1.
- Bubbly input: s_valid toggled randomly (~50%) with m_ready random -> outputs bit-identical to a reference model, count = 4, one frame_done.
- Reset mid-frame: assert rst after 9 beats -> next cycle all outputs 0 and state IDLE. A fresh start plus a full frame gives correct results 5, 7, 13, 15.
- Default IMG_W=28, IMG_H=28, two back-to-back frames (start reissued after frame_done) -> 196 outputs per frame, no line-buffer contamination across frames.
